// File: rtl/button_pkg.sv
// Shared types for the button/switch front end (key_debouncer FSM states, idle key level).
// The debounce FSM is built only when BUTTON_DEBOUNCE_EN is defined.
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WT, PRESSED, REL_WT} key_state_t;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: synchronizer chain, then debounce FSM (BUTTON_DEBOUNCE_EN) or a
// direct edge detector, producing a clean level plus one-cycle press/release strobes.
module key_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_pulse,
  output logic key_release
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic p;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{KEY_RELEASED}};
    else       sync_q <= sync_d;
  end

  assign p = ~sync_q[SYNC_STAGES-1];

  logic level_q, level_d;
  logic pulse_q, pulse_d;
  logic release_q, release_d;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that moves the FSM out of a settled state is the first stable one,
  // so the wait states need DEBOUNCE_CYCLES-1 further matching samples.
  localparam bit INSTANT = (DEBOUNCE_CYCLES < 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INSTANT ? 0 : DEBOUNCE_CYCLES - 2);

  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (p) begin
          cnt_d = '0;
          if (INSTANT) begin
            state_d = PRESSED;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_WT;
          end
        end
      end
      PRESS_WT: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          cnt_d = '0;
          if (INSTANT) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = REL_WT;
          end
        end
      end
      REL_WT: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    level_d   = p;
    pulse_d   = p & ~level_q;
    release_d = ~p & level_q;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_pulse   = pulse_q;
  assign key_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Board input front end: per-key synchronize/debounce/strobe (debounce FSM when
// BUTTON_DEBOUNCE_EN is defined) and synchronized switches with an any-change strobe.
module button_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_sync,
  output logic                sw_changed
);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clock      (clock),
      .reset      (reset),
      .key_n      (key_n[gi]),
      .key_level  (key_level[gi]),
      .key_pulse  (key_pulse[gi]),
      .key_release(key_release[gi])
    );
  end

  logic [NUM_SW-1:0] sw_sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] sw_sync_d [SYNC_STAGES];
  logic [NUM_SW-1:0] sw_prev_q, sw_prev_d;
  logic              sw_changed_q, sw_changed_d;

  always_comb begin
    sw_sync_d[0] = sw;
    for (int i = 1; i < SYNC_STAGES; i++) sw_sync_d[i] = sw_sync_q[i-1];
    sw_prev_d    = sw_sync_q[SYNC_STAGES-1];
    // Prev register starts at the same reset value, so no strobe right after reset.
    sw_changed_d = |(sw_sync_q[SYNC_STAGES-1] ^ sw_prev_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      sw_prev_q    <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_d[i];
      sw_prev_q    <= sw_prev_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign sw_sync    = sw_sync_q[SYNC_STAGES-1];
  assign sw_changed = sw_changed_q;

endmodule
